// File: rtl/float_mult_pipe.sv
// Parametrised floating-point multiplier: 4-stage pipeline (unpack, multiply, normalise, round/pack)
// with valid/ready handshake. Define FLOAT_MULT_RNE_EN for round-to-nearest-even, else round-half-up.
module float_mult_pipe #(
   parameter int EXP_W = 5,
   parameter int MAN_W = 10,
   parameter int TAG_W = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_n_i,
   input  logic                     valid_i,
   output logic                     ready_o,
   input  logic [EXP_W+MAN_W:0]     data_1_i,
   input  logic [EXP_W+MAN_W:0]     data_2_i,
   input  logic [TAG_W-1:0]         tag_i,
   output logic                     valid_o,
   input  logic                     ready_i,
   output logic [EXP_W+MAN_W:0]     data_mult_o,
   output logic [TAG_W-1:0]         tag_o
);

   localparam int W    = 1 + EXP_W + MAN_W;
   localparam int ES_W = EXP_W + 2;
   localparam int P_W  = 2 * MAN_W + 2;

   localparam logic signed [ES_W-1:0] BIAS_ES = ES_W'((1 << (EXP_W - 1)) - 1);
   localparam logic signed [ES_W-1:0] EMAX_ES = ES_W'((1 << EXP_W) - 1);
   localparam logic signed [ES_W-1:0] ZERO_ES = {ES_W{1'b0}};
   localparam logic signed [ES_W-1:0] ONE_ES  = {{(ES_W-1){1'b0}}, 1'b1};

   logic en_s;

   // stage 1 registers
   logic                   s1_valid_q, s1_zero_q, s1_sign_q;
   logic signed [ES_W-1:0] s1_esum_q;
   logic [MAN_W:0]         s1_man_a_q, s1_man_b_q;
   logic [TAG_W-1:0]       s1_tag_q;
   // stage 2 registers
   logic                   s2_valid_q, s2_zero_q, s2_sign_q;
   logic signed [ES_W-1:0] s2_esum_q;
   logic [P_W-1:0]         s2_prod_q;
   logic [TAG_W-1:0]       s2_tag_q;
   // stage 3 registers
   logic                   s3_valid_q, s3_zero_q, s3_sign_q;
   logic signed [ES_W-1:0] s3_esum_q;
   logic [MAN_W-1:0]       s3_man_q;
   logic                   s3_guard_q, s3_sticky_q;
   logic [TAG_W-1:0]       s3_tag_q;
   // output registers
   logic                   s4_valid_q;
   logic [W-1:0]           s4_data_q;
   logic [TAG_W-1:0]       s4_tag_q;

   // next-state values
   logic                   s1_zero_d, s1_sign_d;
   logic signed [ES_W-1:0] s1_esum_d;
   logic [MAN_W:0]         s1_man_a_d, s1_man_b_d;
   logic [P_W-1:0]         s2_prod_d;
   logic [P_W-2:0]         norm_s;
   logic signed [ES_W-1:0] s3_esum_d;
   logic [MAN_W-1:0]       s3_man_d;
   logic                   s3_guard_d, s3_sticky_d;
   logic                   inc_s;
   logic [MAN_W:0]         man_rnd_s;
   logic [MAN_W-1:0]       man_fin_s;
   logic signed [ES_W-1:0] esum_fin_s;
   logic [W-1:0]           s4_data_d;

   assign en_s        = ready_i | ~s4_valid_q;
   assign ready_o     = en_s;
   assign valid_o     = s4_valid_q;
   assign data_mult_o = s4_data_q;
   assign tag_o       = s4_tag_q;

   // unpack: zero detect (denormals flushed), sign, biased exponent sum, hidden-one mantissas
   always_comb begin
      s1_zero_d  = (data_1_i[W-2 -: EXP_W] == {EXP_W{1'b0}}) |
                   (data_2_i[W-2 -: EXP_W] == {EXP_W{1'b0}});
      s1_sign_d  = data_1_i[W-1] ^ data_2_i[W-1];
      s1_esum_d  = $signed({2'b00, data_1_i[W-2 -: EXP_W]}) +
                   $signed({2'b00, data_2_i[W-2 -: EXP_W]}) - BIAS_ES;
      s1_man_a_d = {1'b1, data_1_i[MAN_W-1:0]};
      s1_man_b_d = {1'b1, data_2_i[MAN_W-1:0]};
   end

   // multiply
   always_comb begin
      s2_prod_d = P_W'(s1_man_a_q) * P_W'(s1_man_b_q);
   end

   // normalise: product lies in [1,4); norm_s drops the leading one so its top MAN_W bits are the mantissa
   always_comb begin
      if (s2_prod_q[P_W-1]) begin
         norm_s    = s2_prod_q[P_W-2:0];
         s3_esum_d = s2_esum_q + ONE_ES;
      end else begin
         norm_s    = {s2_prod_q[P_W-3:0], 1'b0};
         s3_esum_d = s2_esum_q;
      end
      s3_man_d    = norm_s[P_W-2 -: MAN_W];
      s3_guard_d  = norm_s[MAN_W];
      s3_sticky_d = |norm_s[MAN_W-1:0];
   end

   // round, renormalise on mantissa carry, then flush-to-zero / saturate / pack
   always_comb begin
`ifdef FLOAT_MULT_RNE_EN
      inc_s = s3_guard_q & (s3_sticky_q | s3_man_q[0]);
`else
      inc_s = s3_guard_q;
`endif
      man_rnd_s = {1'b0, s3_man_q} + {{MAN_W{1'b0}}, inc_s};
      if (man_rnd_s[MAN_W]) begin
         man_fin_s  = {MAN_W{1'b0}};
         esum_fin_s = s3_esum_q + ONE_ES;
      end else begin
         man_fin_s  = man_rnd_s[MAN_W-1:0];
         esum_fin_s = s3_esum_q;
      end
      if (s3_zero_q || (esum_fin_s <= ZERO_ES)) begin
         s4_data_d = {W{1'b0}};
      end else if (esum_fin_s > EMAX_ES) begin
         s4_data_d = {s3_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b1}}};
      end else begin
         s4_data_d = {s3_sign_q, esum_fin_s[EXP_W-1:0], man_fin_s};
      end
   end

   // pipeline registers: all stages advance together on en_s, hold otherwise
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         s1_valid_q  <= 1'b0;
         s1_zero_q   <= 1'b0;
         s1_sign_q   <= 1'b0;
         s1_esum_q   <= ZERO_ES;
         s1_man_a_q  <= {(MAN_W+1){1'b0}};
         s1_man_b_q  <= {(MAN_W+1){1'b0}};
         s1_tag_q    <= {TAG_W{1'b0}};
         s2_valid_q  <= 1'b0;
         s2_zero_q   <= 1'b0;
         s2_sign_q   <= 1'b0;
         s2_esum_q   <= ZERO_ES;
         s2_prod_q   <= {P_W{1'b0}};
         s2_tag_q    <= {TAG_W{1'b0}};
         s3_valid_q  <= 1'b0;
         s3_zero_q   <= 1'b0;
         s3_sign_q   <= 1'b0;
         s3_esum_q   <= ZERO_ES;
         s3_man_q    <= {MAN_W{1'b0}};
         s3_guard_q  <= 1'b0;
         s3_sticky_q <= 1'b0;
         s3_tag_q    <= {TAG_W{1'b0}};
         s4_valid_q  <= 1'b0;
         s4_data_q   <= {W{1'b0}};
         s4_tag_q    <= {TAG_W{1'b0}};
      end else if (en_s) begin
         s1_valid_q  <= valid_i;
         s1_zero_q   <= s1_zero_d;
         s1_sign_q   <= s1_sign_d;
         s1_esum_q   <= s1_esum_d;
         s1_man_a_q  <= s1_man_a_d;
         s1_man_b_q  <= s1_man_b_d;
         s1_tag_q    <= tag_i;
         s2_valid_q  <= s1_valid_q;
         s2_zero_q   <= s1_zero_q;
         s2_sign_q   <= s1_sign_q;
         s2_esum_q   <= s1_esum_q;
         s2_prod_q   <= s2_prod_d;
         s2_tag_q    <= s1_tag_q;
         s3_valid_q  <= s2_valid_q;
         s3_zero_q   <= s2_zero_q;
         s3_sign_q   <= s2_sign_q;
         s3_esum_q   <= s3_esum_d;
         s3_man_q    <= s3_man_d;
         s3_guard_q  <= s3_guard_d;
         s3_sticky_q <= s3_sticky_d;
         s3_tag_q    <= s2_tag_q;
         s4_valid_q  <= s3_valid_q;
         s4_data_q   <= s4_data_d;
         s4_tag_q    <= s3_tag_q;
      end
   end

endmodule

// File: tb/tb_float_mult_pipe.sv
// Bench for float_mult_pipe (default parameters): directed table, random stream against an
// arithmetic reference model, backpressure and mid-stream reset sequences.
module tb_float_mult_pipe;

   logic        clk_i = 1'b0;
   logic        rst_n_i = 1'b0;
   logic        valid_i = 1'b0;
   logic        ready_i = 1'b1;
   logic [15:0] data_1_i = 16'h0000;
   logic [15:0] data_2_i = 16'h0000;
   logic [3:0]  tag_i = 4'h0;
   logic        ready_o, valid_o;
   logic [15:0] data_mult_o;
   logic [3:0]  tag_o;

   float_mult_pipe #(.EXP_W(5), .MAN_W(10), .TAG_W(4)) dut (
      .clk_i(clk_i), .rst_n_i(rst_n_i), .valid_i(valid_i), .ready_o(ready_o),
      .data_1_i(data_1_i), .data_2_i(data_2_i), .tag_i(tag_i),
      .valid_o(valid_o), .ready_i(ready_i), .data_mult_o(data_mult_o), .tag_o(tag_o)
   );

   always #5 clk_i = ~clk_i;

   int n_checks = 0;
   int n_err    = 0;
   int cyc      = 0;
   int rdy_mode = 0;
   int stall_cnt = 0;

   typedef struct { logic [15:0] d; logic [3:0] t; int acc; bit lat; } exp_t;
   exp_t sb[$];

   typedef struct { logic [15:0] a; logic [15:0] b; logic [3:0] t; logic [15:0] e; } vec_t;
   vec_t vecs[10];

   always @(posedge clk_i) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // reference: real-valued product of two normal numbers, rounded and range-limited
   function automatic logic [15:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
      int     ea, eb, e, q, rem, half;
      longint p;
      logic   s;
      ea = int'(a[14:10]);
      eb = int'(b[14:10]);
      s  = a[15] ^ b[15];
      if (ea == 0 || eb == 0) return 16'h0000;
      p = longint'(1024 + int'(a[9:0])) * longint'(1024 + int'(b[9:0]));
      e = ea + eb - 15;
      if (p >= 64'd2097152) begin
         e = e + 1; q = int'(p / 2048); rem = int'(p % 2048); half = 1024;
      end else begin
         q = int'(p / 1024); rem = int'(p % 1024); half = 512;
      end
`ifdef FLOAT_MULT_RNE_EN
      if (rem > half || (rem == half && (q % 2) == 1)) q = q + 1;
`else
      if (rem >= half) q = q + 1;
`endif
      if (q == 2048) begin q = 1024; e = e + 1; end
      if (e <= 0) return 16'h0000;
      if (e > 31) return {s, 15'h7fff};
      return {s, 5'(e), 10'(q - 1024)};
   endfunction

   // downstream ready pattern
   always @(negedge clk_i) begin
      case (rdy_mode)
         1: ready_i = ($urandom_range(0, 3) != 0);
         2: begin
            ready_i = !(stall_cnt >= 4 && stall_cnt < 7);
            stall_cnt++;
         end
         default: ready_i = 1'b1;
      endcase
   end

   logic [15:0] held_d;
   logic [3:0]  held_t;
   bit          was_stall = 1'b0;
   exp_t        mon_e;

   // output monitor, sampled just before the rising edge
   always @(negedge clk_i) begin
      #4;
      if (!rst_n_i) begin
         was_stall = 1'b0;
      end else begin
         if (was_stall) begin
            chk("hold_valid", 32'(valid_o), 32'd1);
            chk("hold_data", 32'(data_mult_o), 32'(held_d));
            chk("hold_tag", 32'(tag_o), 32'(held_t));
         end
         if (valid_o && !ready_i) begin
            chk("stall_ready_o", 32'(ready_o), 32'd0);
            held_d = data_mult_o;
            held_t = tag_o;
            was_stall = 1'b1;
         end else begin
            was_stall = 1'b0;
         end
         if (valid_o && ready_i) begin
            if (sb.size() == 0) begin
               n_checks++;
               n_err++;
               $display("FAIL unexpected_out: got data %h tag %h expected no result", data_mult_o, tag_o);
            end else begin
               mon_e = sb.pop_front();
               chk("data", 32'(data_mult_o), 32'(mon_e.d));
               chk("tag", 32'(tag_o), 32'(mon_e.t));
               if (mon_e.lat) chk("latency", 32'(cyc - mon_e.acc), 32'd3);
            end
         end
      end
   end

   task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [3:0] t,
                       input logic [15:0] e, input bit lat);
      int  waited = 0;
      bit  done = 1'b0;
      @(negedge clk_i);
      valid_i = 1'b1; data_1_i = a; data_2_i = b; tag_i = t;
      while (!done) begin
         #4;
         if (ready_o) begin
            @(posedge clk_i);
            #1;
            sb.push_back('{d: e, t: t, acc: cyc, lat: lat});
            done = 1'b1;
         end else begin
            @(posedge clk_i);
            waited++;
            if (waited > 200) begin
               n_checks++;
               n_err++;
               $display("FAIL accept_timeout: got ready_o=0 for %0d cycles expected acceptance", waited);
               done = 1'b1;
            end else begin
               @(negedge clk_i);
            end
         end
      end
   endtask

   task automatic idle();
      @(negedge clk_i);
      valid_i = 1'b0;
   endtask

   task automatic drain();
      int k = 0;
      while (sb.size() != 0 && k < 300) begin
         @(posedge clk_i);
         k++;
      end
      #2;
      chk("drain_empty", 32'(sb.size()), 32'd0);
   endtask

   initial begin
      logic [15:0] ra, rb;
      vecs[0] = '{16'h3C00, 16'h4000, 4'd3,  16'h4000};
      vecs[1] = '{16'h3E00, 16'h3E00, 4'd5,  16'h4080};
      vecs[2] = '{16'h0000, 16'h4000, 4'd1,  16'h0000};
      vecs[3] = '{16'h8000, 16'hC000, 4'd2,  16'h0000};
      vecs[4] = '{16'h0400, 16'h3800, 4'd4,  16'h0000};
      vecs[5] = '{16'h7800, 16'h4000, 4'd6,  16'h7C00};
      vecs[6] = '{16'h7800, 16'h4400, 4'd7,  16'h7FFF};
      vecs[7] = '{16'hF800, 16'h4400, 4'd8,  16'hFFFF};
`ifdef FLOAT_MULT_RNE_EN
      vecs[8] = '{16'h3C03, 16'h3E00, 4'd9,  16'h3E04};
`else
      vecs[8] = '{16'h3C03, 16'h3E00, 4'd9,  16'h3E05};
`endif
      vecs[9] = '{16'h3C01, 16'h3C01, 4'd10, 16'h3C02};

      // reset state
      #12;
      chk("rst_valid_o", 32'(valid_o), 32'd0);
      chk("rst_data", 32'(data_mult_o), 32'd0);
      chk("rst_tag", 32'(tag_o), 32'd0);
      chk("rst_ready_o", 32'(ready_o), 32'd1);
      @(negedge clk_i);
      rst_n_i = 1'b1;

      // directed table, back-to-back with ready_i high
      rdy_mode = 0;
      for (int i = 0; i < 10; i++) send(vecs[i].a, vecs[i].b, vecs[i].t, vecs[i].e, 1'b1);
      idle();
      drain();

      // random operands, random downstream ready, random input bubbles
      rdy_mode = 1;
      for (int i = 0; i < 300; i++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         if ($urandom_range(0, 3) == 0) rb[14:10] = 5'd30 - ra[14:10];
         send(ra, rb, 4'($urandom), ref_mul(ra, rb), 1'b0);
         if ($urandom_range(0, 4) == 0) idle();
      end
      idle();
      drain();

      // backpressure: tags 0..7 back-to-back, ready_i low for 3 cycles mid-stream
      @(negedge clk_i);
      stall_cnt = 0;
      rdy_mode = 2;
      for (int i = 0; i < 8; i++) begin
         ra = 16'h3C00 + 16'(i * 37);
         rb = 16'h4100 + 16'(i * 113);
         send(ra, rb, 4'(i), ref_mul(ra, rb), 1'b0);
      end
      idle();
      drain();
      rdy_mode = 0;

      // reset with one result at the output and three in flight
      for (int i = 0; i < 4; i++) send(16'h3C00 + 16'(i), 16'h4000, 4'(i + 1), ref_mul(16'h3C00 + 16'(i), 16'h4000), 1'b1);
      #1;
      chk("pre_reset_valid", 32'(valid_o), 32'd1);
      rst_n_i = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(valid_o), 32'd0);
      chk("mid_rst_data", 32'(data_mult_o), 32'd0);
      chk("mid_rst_tag", 32'(tag_o), 32'd0);
      sb.delete();
      valid_i = 1'b0;
      repeat (3) @(negedge clk_i);
      rst_n_i = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk_i);
         #4;
         chk("no_stale", 32'(valid_o), 32'd0);
      end

      // pipeline usable after reset
      send(vecs[1].a, vecs[1].b, vecs[1].t, vecs[1].e, 1'b1);
      idle();
      drain();

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
